// File: rtl/rs485_frame_rx.sv
// rs485_frame_rx
//   RS485 receive front-end. It over-samples the line, deserialises 8N1 bytes,
//   parses 4-byte command frames (HEADER, channel, data, checksum) and writes
//   validated data into NUM_CH 8-bit channel registers.
//
// Handshake: rx_byte_vld and ch_update are single-cycle strobes with no
//   back-pressure. rx_byte and ch_data hold their values between strobes.
//
// Ports
//   sys_clk        system clock
//   sys_rst_n      asynchronous active-low reset
//   rs485_uart_rxd serial line, idle high (asynchronous)
//   ch_data        channel registers, channel k in bits [8k+7:8k]
//   ch_update      one-cycle pulse on bit k when channel k is written
//   rx_byte        last byte received with a good stop bit
//   rx_byte_vld    one-cycle pulse when rx_byte updates
//   frame_err      one-cycle pulse on any error event
//   err_cnt        saturating count of error events
module rs485_frame_rx #(
    parameter int          CLK_FREQ     = 50_000_000,
    parameter int          UART_BPS     = 115200,
    parameter int          NUM_CH       = 4,
    parameter logic [7:0]  HEADER       = 8'hA5,
    parameter int          TIMEOUT_BITS = 20,
    parameter logic [7:0]  CH_RST_VAL   = 8'h00
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                rs485_uart_rxd,
    output logic [NUM_CH*8-1:0] ch_data,
    output logic [NUM_CH-1:0]   ch_update,
    output logic [7:0]          rx_byte,
    output logic                rx_byte_vld,
    output logic                frame_err,
    output logic [7:0]          err_cnt
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int HALF    = BPS_CNT / 2;
    localparam int TO_CLKS = TIMEOUT_BITS * BPS_CNT;
    localparam int CW      = $clog2(BPS_CNT + 1);
    localparam int TW      = $clog2(TO_CLKS + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {P_IDLE, P_CH, P_DATA, P_SUM} p_state_t;

    rx_state_t rx_state, rx_next;
    p_state_t  p_state, p_next;

    logic          rxd_s1, rxd_s2, rxd_d;
    logic          fall;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          half_tick, bit_tick;
    logic          stop_ok, stop_bad;
    logic [7:0]    ch_reg, data_reg;
    logic [TW-1:0] to_cnt;
    logic          timeout;
    logic          frame_done, frame_good, sum_err, err_evt;

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_d  <= 1'b1;
        end else begin
            rxd_s1 <= rs485_uart_rxd;
            rxd_s2 <= rxd_s1;
            rxd_d  <= rxd_s2;
        end
    end

    assign fall      = rxd_d & ~rxd_s2;
    assign half_tick = (bit_cnt == CW'(HALF - 1));
    assign bit_tick  = (bit_cnt == CW'(BPS_CNT - 1));

    // ---------------- byte receiver FSM ----------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) rx_state <= RX_IDLE;
        else            rx_state <= rx_next;
    end

    always_comb begin
        rx_next  = rx_state;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        case (rx_state)
            RX_IDLE:  if (fall) rx_next = RX_START;
            // A line already high again at mid start bit was a glitch.
            RX_START: if (half_tick) rx_next = rxd_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_tick && bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is seen.
                if (bit_tick) begin
                    rx_next  = RX_IDLE;
                    stop_ok  = rxd_s2;
                    stop_bad = ~rxd_s2;
                end
            end
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            rx_byte     <= '0;
            rx_byte_vld <= 1'b0;
        end else begin
            if (rx_state == RX_IDLE || (rx_state == RX_START && half_tick) || bit_tick)
                bit_cnt <= '0;
            else
                bit_cnt <= bit_cnt + 1'b1;

            if (rx_state == RX_START)
                bit_idx <= '0;
            else if (rx_state == RX_DATA && bit_tick) begin
                shift_reg <= {rxd_s2, shift_reg[7:1]};
                bit_idx   <= bit_idx + 1'b1;
            end

            rx_byte_vld <= stop_ok;
            if (stop_ok) rx_byte <= shift_reg;
        end
    end

    // ---------------- frame parser FSM ----------------
    assign timeout    = (p_state != P_IDLE) && (to_cnt == TW'(TO_CLKS - 1));
    assign frame_done = (p_state == P_SUM) && rx_byte_vld;
    assign frame_good = (rx_byte == 8'(ch_reg + data_reg)) && (ch_reg < 8'(NUM_CH));
    assign sum_err    = frame_done && !frame_good;
    // OR-ing keeps coincident error sources to a single count.
    assign err_evt    = stop_bad | timeout | sum_err;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) p_state <= P_IDLE;
        else            p_state <= p_next;
    end

    always_comb begin
        p_next = p_state;
        if (stop_bad || timeout)
            p_next = P_IDLE;
        else if (rx_byte_vld) begin
            case (p_state)
                // HEADER only resynchronises from P_IDLE; mid-frame it is data.
                P_IDLE:  if (rx_byte == HEADER) p_next = P_CH;
                P_CH:    p_next = P_DATA;
                P_DATA:  p_next = P_SUM;
                P_SUM:   p_next = P_IDLE;
                default: p_next = P_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ch_reg    <= '0;
            data_reg  <= '0;
            to_cnt    <= '0;
            ch_data   <= {NUM_CH{CH_RST_VAL}};
            ch_update <= '0;
            frame_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            if (rx_byte_vld && p_state == P_CH)   ch_reg   <= rx_byte;
            if (rx_byte_vld && p_state == P_DATA) data_reg <= rx_byte;

            // Inter-byte gap counter, restarted by every byte mid-frame.
            if (p_state == P_IDLE || rx_byte_vld || timeout)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;

            for (int k = 0; k < NUM_CH; k++) begin
                ch_update[k] <= frame_done && frame_good && (ch_reg == 8'(k));
                if (frame_done && frame_good && (ch_reg == 8'(k)))
                    ch_data[8*k +: 8] <= data_reg;
            end

            frame_err <= err_evt;
            if (err_evt && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_rs485_frame_rx.sv
// tb_rs485_frame_rx
//   Directed bench for rs485_frame_rx with a 16-clock bit period.
//   Serial bytes are driven on the line, strobe outputs are counted by a
//   monitor, and values are compared against hand-computed constants.
module tb_rs485_frame_rx;

    localparam int CLK_FREQ = 1_000_000;
    localparam int UART_BPS = 62_500;
    localparam int BPS      = CLK_FREQ / UART_BPS;   // 16
    localparam int NUM_CH   = 4;
    localparam int TO_BITS  = 20;

    logic                sys_clk = 1'b0;
    logic                sys_rst_n = 1'b0;
    logic                rs485_uart_rxd = 1'b1;
    logic [NUM_CH*8-1:0] ch_data;
    logic [NUM_CH-1:0]   ch_update;
    logic [7:0]          rx_byte;
    logic                rx_byte_vld;
    logic                frame_err;
    logic [7:0]          err_cnt;

    int n_cmp = 0;
    int n_err = 0;

    rs485_frame_rx #(
        .CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .NUM_CH(NUM_CH),
        .HEADER(8'hA5), .TIMEOUT_BITS(TO_BITS), .CH_RST_VAL(8'h00)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rs485_uart_rxd(rs485_uart_rxd),
        .ch_data(ch_data), .ch_update(ch_update), .rx_byte(rx_byte),
        .rx_byte_vld(rx_byte_vld), .frame_err(frame_err), .err_cnt(err_cnt)
    );

    // ---------------- clock / watchdog ----------------
    always #5 sys_clk = ~sys_clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- monitor ----------------
    int          cyc = 0;
    int          vld_pulses = 0;
    int          err_pulses = 0;
    int          upd_pulses = 0;
    int          last_vld_cyc = 0;
    int          err_cyc = 0;
    logic [3:0]  last_upd = '0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (rx_byte_vld) begin
                vld_pulses   <= vld_pulses + 1;
                last_vld_cyc <= cyc;
            end
            if (frame_err) begin
                err_pulses <= err_pulses + 1;
                err_cyc    <= cyc;
            end
            if (ch_update != '0) begin
                upd_pulses <= upd_pulses + 1;
                last_upd   <= ch_update;
            end
        end
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive_bit(input logic v, input int n);
        rs485_uart_rxd = v;
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_bit(1'b0, BPS);
        for (int i = 0; i < 8; i++) drive_bit(b[i], BPS);
        drive_bit(stop, BPS);
        rs485_uart_rxd = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b0, b1, b2, b3);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
        send_byte(b3, 1'b1);
    endtask

    task automatic idle(input int n);
        drive_bit(1'b1, n);
    endtask

    // ---------------- stimulus ----------------
    int v0, e0, u0;

    initial begin
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_ch_data", ch_data, 32'h0000_0000);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("rst_rx_byte", {24'd0, rx_byte}, 32'd0);
        check("rst_strobes", {29'd0, ch_update[0], rx_byte_vld, frame_err}, 32'd0);
        sys_rst_n = 1'b1;
        idle(4 * BPS);

        // Good frame to channel 2.
        v0 = vld_pulses; e0 = err_pulses; u0 = upd_pulses;
        send_frame(8'hA5, 8'h02, 8'h3C, 8'h3E);
        idle(2 * BPS);
        check("f1_vld_count", vld_pulses - v0, 4);
        check("f1_rx_byte", {24'd0, rx_byte}, 32'h3E);
        check("f1_upd_count", upd_pulses - u0, 1);
        check("f1_upd_mask", {28'd0, last_upd}, 32'b0100);
        check("f1_ch_data", ch_data, 32'h003C_0000);
        check("f1_no_err", err_pulses - e0, 0);

        // Bad checksum, then corrected frame to channel 1.
        u0 = upd_pulses; e0 = err_pulses;
        send_frame(8'hA5, 8'h01, 8'h10, 8'h12);
        idle(2 * BPS);
        check("sum_no_upd", upd_pulses - u0, 0);
        check("sum_err_pulse", err_pulses - e0, 1);
        check("sum_err_cnt", {24'd0, err_cnt}, 32'd1);
        send_frame(8'hA5, 8'h01, 8'h10, 8'h11);
        idle(2 * BPS);
        check("f2_ch_data", ch_data, 32'h003C_1000);

        // Channel out of range.
        u0 = upd_pulses; e0 = err_pulses;
        send_frame(8'hA5, 8'h05, 8'h20, 8'h25);
        idle(2 * BPS);
        check("range_no_upd", upd_pulses - u0, 0);
        check("range_err_pulse", err_pulses - e0, 1);
        check("range_ch_data", ch_data, 32'h003C_1000);

        // Junk before a header is ignored silently.
        v0 = vld_pulses;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h5A, 1'b1);
        idle(2 * BPS);
        check("junk_vld_count", vld_pulses - v0, 3);
        check("junk_rx_byte", {24'd0, rx_byte}, 32'h5A);
        check("junk_err_cnt", {24'd0, err_cnt}, 32'd2);

        // Inter-byte timeout after A5 00; error one cycle after the counter expires.
        e0 = err_pulses;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        idle(25 * BPS);
        check("to_err_pulse", err_pulses - e0, 1);
        check("to_latency", err_cyc - last_vld_cyc, TO_BITS * BPS + 1);
        check("to_err_cnt", {24'd0, err_cnt}, 32'd3);
        send_byte(8'h77, 1'b1);
        send_byte(8'h00, 1'b1);
        idle(2 * BPS);
        check("to_ch0_kept", ch_data, 32'h003C_1000);
        check("to_tail_no_err", {24'd0, err_cnt}, 32'd3);
        send_frame(8'hA5, 8'h00, 8'h77, 8'h77);
        idle(2 * BPS);
        check("to_resync_ch0", ch_data, 32'h003C_1077);

        // Stop bit forced low.
        v0 = vld_pulses; e0 = err_pulses;
        send_byte(8'h55, 1'b0);
        idle(3 * BPS);
        check("stop_no_vld", vld_pulses - v0, 0);
        check("stop_err_pulse", err_pulses - e0, 1);
        check("stop_err_cnt", {24'd0, err_cnt}, 32'd4);

        // Short low glitch on an idle line.
        v0 = vld_pulses;
        drive_bit(1'b0, 4);
        idle(12 * BPS);
        check("glitch_no_vld", vld_pulses - v0, 0);
        check("glitch_err_cnt", {24'd0, err_cnt}, 32'd4);

        // Reset in the middle of the data byte of a frame.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        drive_bit(1'b0, BPS);
        drive_bit(1'b1, BPS);
        drive_bit(1'b0, BPS / 2);
        #3 sys_rst_n = 1'b0;
        #1;
        check("arst_ch_data", ch_data, 32'h0000_0000);
        check("arst_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("arst_strobes", {28'd0, ch_update}, 32'd0);
        rs485_uart_rxd = 1'b1;
        repeat (4) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        idle(2 * BPS);
        u0 = upd_pulses;
        send_frame(8'hA5, 8'h03, 8'h01, 8'h04);
        idle(2 * BPS);
        check("post_rst_ch_data", ch_data, 32'h0100_0000);
        check("post_rst_upd_mask", {28'd0, last_upd}, 32'b1000);
        check("post_rst_upd_count", upd_pulses - u0, 1);
        check("post_rst_err_cnt", {24'd0, err_cnt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
